// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline stage register.
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_CNT_W  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stall_ctr.sv
// Saturating up-counter of downstream stall cycles; cleared only by rst.
module pipe_stall_ctr
  import pipe_pkg::*;
#(
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  assign count = count_r;

  // Count stalled cycles, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage: valid/ready in and out with a 2-entry skid and flush.
// Optional stall-cycle counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W
`ifdef PIPE_STALL_CNT_EN
  , parameter int CNT_W = PIPE_CNT_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef PIPE_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cycles
`endif
);

  pipe_state_e       state_r, state_s;
  logic [DATA_W-1:0] main_r, main_s;
  logic [DATA_W-1:0] skid_r, skid_s;
  logic              in_ready_r, out_valid_r;
  logic              in_fire_s, out_fire_s;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;
  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_data   = main_r;

  // Next state and datapath; flush squashes everything but keeps main for out_data.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    if (flush) begin
      state_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            state_s = ONE;
            main_s  = in_data;
          end else begin
            state_s = EMPTY;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_s = ONE;
            main_s  = in_data;
          end else if (in_fire_s) begin
            state_s = FULL;
            skid_s  = in_data;
          end else if (out_fire_s) begin
            state_s = EMPTY;
          end else begin
            state_s = ONE;
          end
        end
        FULL: begin
          if (out_fire_s) begin
            state_s = ONE;
            main_s  = skid_r;
          end else begin
            state_s = FULL;
          end
        end
        default: begin
          state_s = EMPTY;
        end
      endcase
    end
  end

  // State, storage and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      main_r      <= {DATA_W{1'b0}};
      skid_r      <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_s;
      main_r      <= main_s;
      skid_r      <= skid_s;
      out_valid_r <= (state_s != EMPTY);
      in_ready_r  <= (state_s != FULL);
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic stall_s;

  assign stall_s = out_valid_r & ~out_ready;

  pipe_stall_ctr #(
    .CNT_W (CNT_W)
  ) u_stall_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_s),
    .count (stall_cycles)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed plus randomized bench for pipe_skid_reg against a queue-based model.
module tb_pipe_skid_reg;

  localparam int CNT_W_TB  = 4;
  localparam int STALL_MAX = (1 << CNT_W_TB) - 1;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W_TB-1:0] stall_cycles;
`endif

  pipe_skid_reg #(
    .DATA_W (32)
`ifdef PIPE_STALL_CNT_EN
    , .CNT_W (CNT_W_TB)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  logic [31:0] q[$];
  logic [31:0] exp_data;
  int          exp_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model's view of the stage.
  task automatic chk_model(input string tag);
    chk({tag, "/out_valid"}, {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk({tag, "/out_data"}, out_data, exp_data);
    chk({tag, "/in_ready"}, {31'd0, in_ready}, {31'd0, q.size() < 2});
`ifdef PIPE_STALL_CNT_EN
    chk({tag, "/stall"}, {28'd0, stall_cycles}, exp_stall);
`endif
  endtask

  // One clock: drive inputs, advance the FIFO model, then check the DUT.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic f,
                       input string tag);
    bit in_f;
    bit out_f;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    in_f  = v && (q.size() < 2);
    out_f = (q.size() > 0) && r;
    if ((q.size() > 0) && !r && (exp_stall < STALL_MAX)) exp_stall++;
    @(posedge clk);
    #1;
    if (f) begin
      q.delete();
    end else begin
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back(d);
    end
    if (q.size() > 0) exp_data = q[0];
    chk_model(tag);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = $urandom;
    out_ready = 1'(($urandom));
    flush     = 1'(($urandom));
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    exp_data  = 32'd0;
    exp_stall = 0;
    chk("rst/out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst/out_data", out_data, 32'd0);
    chk("rst/in_ready", {31'd0, in_ready}, 32'd1);
`ifdef PIPE_STALL_CNT_EN
    chk("rst/stall", {28'd0, stall_cycles}, 32'd0);
`endif
    rst = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_data  = 32'd0;
    exp_stall = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    #1;

    do_reset();

    // Streaming with one-cycle latency.
    cycle(1'b1, 32'h11, 1'b1, 1'b0, "stream0");
    chk("stream0/data", out_data, 32'h11);
    cycle(1'b1, 32'h22, 1'b1, 1'b0, "stream1");
    chk("stream1/data", out_data, 32'h22);
    cycle(1'b1, 32'h33, 1'b1, 1'b0, "stream2");
    chk("stream2/data", out_data, 32'h33);
    chk("stream2/in_ready", {31'd0, in_ready}, 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, "drain");
    chk("drain/valid", {31'd0, out_valid}, 32'd0);
    chk("drain/data_kept", out_data, 32'h33);

    // Skid: fill to FULL under a stall, then release.
    cycle(1'b1, 32'hA, 1'b0, 1'b0, "skid0");
    cycle(1'b1, 32'hB, 1'b0, 1'b0, "skid1");
    chk("skid1/in_ready", {31'd0, in_ready}, 32'd0);
    chk("skid1/data", out_data, 32'hA);
    cycle(1'b1, 32'hF00, 1'b0, 1'b0, "skid_hold");
    chk("skid_hold/data", out_data, 32'hA);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, "skid_rel0");
    chk("skid_rel0/data", out_data, 32'hB);
    chk("skid_rel0/in_ready", {31'd0, in_ready}, 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, "skid_rel1");
    chk("skid_rel1/valid", {31'd0, out_valid}, 32'd0);

    // Flush in FULL with a word offered; then flush in ONE with a real in_fire.
    cycle(1'b1, 32'hA, 1'b0, 1'b0, "fl_fill0");
    cycle(1'b1, 32'hB, 1'b0, 1'b0, "fl_fill1");
    cycle(1'b1, 32'hC, 1'b0, 1'b1, "flush_full");
    chk("flush_full/valid", {31'd0, out_valid}, 32'd0);
    chk("flush_full/in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_full/data_kept", out_data, 32'hA);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, "after_flush");
    chk("after_flush/valid", {31'd0, out_valid}, 32'd0);
    cycle(1'b1, 32'hD, 1'b0, 1'b0, "fl_one0");
    cycle(1'b1, 32'hE, 1'b1, 1'b1, "flush_one");
    chk("flush_one/valid", {31'd0, out_valid}, 32'd0);
    chk("flush_one/data_kept", out_data, 32'hD);

    // Simultaneous in_fire and out_fire in ONE.
    cycle(1'b1, 32'h55, 1'b0, 1'b0, "simul0");
    cycle(1'b1, 32'h66, 1'b1, 1'b0, "simul1");
    chk("simul1/data", out_data, 32'h66);
    chk("simul1/in_ready", {31'd0, in_ready}, 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, "simul_drain");

    // Long stall: counter saturates, survives flush, cleared by reset.
    cycle(1'b1, 32'h77, 1'b0, 1'b0, "stall_load");
    for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, "stall");
    chk("stall/data", out_data, 32'h77);
`ifdef PIPE_STALL_CNT_EN
    chk("stall/saturated", {28'd0, stall_cycles}, 32'd15);
`endif
    cycle(1'b0, 32'h0, 1'b0, 1'b1, "stall_flush");
`ifdef PIPE_STALL_CNT_EN
    chk("stall_flush/kept", {28'd0, stall_cycles}, 32'd15);
`endif
    do_reset();

    // Randomized traffic against the FIFO model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
